// File: rtl/integer_issue_queue_pkg.sv
// Shared types and sizing for the integer issue queue: entry payload, queue/active-list geometry,
// and small helpers for wakeup tag matching and active-list age.
package integer_issue_queue_pkg;

  localparam int INT_QUEUE_SIZE       = 8;
  localparam int INT_QUEUE_SIZE_INDEX = 3;
  localparam int PHYS_REG_INDEX       = 6;
  localparam int ACTIVE_LIST_SIZE     = 16;
  localparam int ACTIVE_LIST_INDEX    = 4;

  typedef struct packed {
    logic [PHYS_REG_INDEX-1:0]    src1;
    logic [PHYS_REG_INDEX-1:0]    src2;
    logic                         uses_rs;
    logic                         uses_rt;
    logic                         uses_immediate;
    logic [15:0]                  immediate_data;
    logic [ACTIVE_LIST_INDEX-1:0] active_list_id;
    logic                         is_branch;
    logic                         prediction;
    logic [31:0]                  recovery_target;
  } int_iq_entry_t;

  function automatic logic tag_hit(input logic [1:0] wb_valid,
                                   input logic [1:0][PHYS_REG_INDEX-1:0] wb_tag,
                                   input logic [PHYS_REG_INDEX-1:0] tag);
    return (wb_valid[0] && (wb_tag[0] == tag)) || (wb_valid[1] && (wb_tag[1] == tag));
  endfunction

  // Distance from the active-list head; larger means younger.
  function automatic logic [ACTIVE_LIST_INDEX-1:0] al_age(input logic [ACTIVE_LIST_INDEX-1:0] id,
                                                          input logic [ACTIVE_LIST_INDEX-1:0] head);
    return ACTIVE_LIST_INDEX'((int'(id) - int'(head) + ACTIVE_LIST_SIZE) % ACTIVE_LIST_SIZE);
  endfunction

endpackage

// File: rtl/integer_issue_queue_if.sv
// Rename/wakeup/dispatch/flush bus into the integer issue queue and its registered status outputs.
interface integer_issue_queue_if #(
  parameter int INT_QUEUE_SIZE       = integer_issue_queue_pkg::INT_QUEUE_SIZE,
  parameter int INT_QUEUE_SIZE_INDEX = integer_issue_queue_pkg::INT_QUEUE_SIZE_INDEX
);
  import integer_issue_queue_pkg::*;

  logic                                  alloc_valid;
  int_iq_entry_t                         alloc_entry;
  logic                                  alloc_src1_ready;
  logic                                  alloc_src2_ready;
  logic                                  alloc_ready;
  logic [1:0]                            wb_valid;
  logic [1:0][PHYS_REG_INDEX-1:0]        wb_tag;
  logic                                  dispatch_valid;
  logic [INT_QUEUE_SIZE_INDEX-1:0]       dispatch_index;
  logic                                  flush_valid;
  logic [ACTIVE_LIST_INDEX-1:0]          flush_branch_id;
  logic [ACTIVE_LIST_INDEX-1:0]          al_head_id;
  logic [INT_QUEUE_SIZE-1:0]             entry_available_bit;
  logic [INT_QUEUE_SIZE-1:0]             ready_bit_src1;
  logic [INT_QUEUE_SIZE-1:0]             ready_bit_src2;
  int_iq_entry_t [INT_QUEUE_SIZE-1:0]    entries;
  logic [INT_QUEUE_SIZE_INDEX:0]         occupancy;

  modport master (
    output alloc_valid, alloc_entry, alloc_src1_ready, alloc_src2_ready,
           wb_valid, wb_tag, dispatch_valid, dispatch_index,
           flush_valid, flush_branch_id, al_head_id,
    input  alloc_ready, entry_available_bit, ready_bit_src1, ready_bit_src2,
           entries, occupancy
  );

  modport slave (
    input  alloc_valid, alloc_entry, alloc_src1_ready, alloc_src2_ready,
           wb_valid, wb_tag, dispatch_valid, dispatch_index,
           flush_valid, flush_branch_id, al_head_id,
    output alloc_ready, entry_available_bit, ready_bit_src1, ready_bit_src2,
           entries, occupancy
  );

endinterface

// File: rtl/priority_encoder.sv
// Priority encoder over a request vector; bottom_up=1 picks the lowest set bit, else the highest.
// Purely combinational, no backpressure.
module priority_encoder #(
  parameter int WIDTH     = 8,
  parameter int INDEX_W   = 3,
  parameter bit bottom_up = 1'b1
) (
  input  logic [WIDTH-1:0]   req,
  output logic [INDEX_W-1:0] idx,
  output logic               found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (bottom_up) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req[i]) begin
          idx   = INDEX_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req[i]) begin
          idx   = INDEX_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/integer_issue_queue.sv
// Integer issue queue: allocation visible next cycle, wakeup/dispatch/flush take effect at the next edge;
// alloc_ready is low when full (alloc ignored). INT_IQ_SELECTIVE_FLUSH_EN enables age-based flush.
module integer_issue_queue #(
  parameter int INT_QUEUE_SIZE       = integer_issue_queue_pkg::INT_QUEUE_SIZE,
  parameter int INT_QUEUE_SIZE_INDEX = integer_issue_queue_pkg::INT_QUEUE_SIZE_INDEX
) (
  input logic                  clk,
  input logic                  rst,
  integer_issue_queue_if.slave iq
);
  import integer_issue_queue_pkg::*;

  logic [INT_QUEUE_SIZE-1:0]          avail_q, avail_d;
  logic [INT_QUEUE_SIZE-1:0]          rdy1_q, rdy1_d;
  logic [INT_QUEUE_SIZE-1:0]          rdy2_q, rdy2_d;
  int_iq_entry_t [INT_QUEUE_SIZE-1:0] entries_q, entries_d;
  logic [INT_QUEUE_SIZE_INDEX:0]      occ_q, occ_d;
  logic [INT_QUEUE_SIZE-1:0]          flush_mask;
  logic [INT_QUEUE_SIZE_INDEX-1:0]    free_idx;
  logic                               free_found;

  priority_encoder #(
    .WIDTH    (INT_QUEUE_SIZE),
    .INDEX_W  (INT_QUEUE_SIZE_INDEX),
    .bottom_up(1'b1)
  ) u_free_pe (
    .req  (avail_q),
    .idx  (free_idx),
    .found(free_found)
  );

`ifdef INT_IQ_SELECTIVE_FLUSH_EN
  // Keep the branch and everything older; drop only younger entries.
  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < INT_QUEUE_SIZE; i++) begin
      flush_mask[i] = al_age(entries_q[i].active_list_id, iq.al_head_id) >
                      al_age(iq.flush_branch_id, iq.al_head_id);
    end
  end
`else
  logic unused_flush_ctx;
  assign flush_mask       = '1;
  assign unused_flush_ctx = ^{iq.al_head_id, iq.flush_branch_id};
`endif

  always_comb begin
    avail_d   = avail_q;
    rdy1_d    = rdy1_q;
    rdy2_d    = rdy2_q;
    entries_d = entries_q;
    occ_d     = '0;
    for (int i = 0; i < INT_QUEUE_SIZE; i++) begin
      if (!avail_q[i]) begin
        if (tag_hit(iq.wb_valid, iq.wb_tag, entries_q[i].src1)) rdy1_d[i] = 1'b1;
        if (tag_hit(iq.wb_valid, iq.wb_tag, entries_q[i].src2)) rdy2_d[i] = 1'b1;
      end
    end
    if (iq.dispatch_valid) avail_d[iq.dispatch_index] = 1'b1;
    if (iq.flush_valid) begin
      avail_d = avail_d | flush_mask;
    end else if (iq.alloc_valid && free_found) begin
      avail_d[free_idx]   = 1'b0;
      entries_d[free_idx] = iq.alloc_entry;
      rdy1_d[free_idx]    = iq.alloc_src1_ready || !iq.alloc_entry.uses_rs ||
                            tag_hit(iq.wb_valid, iq.wb_tag, iq.alloc_entry.src1);
      rdy2_d[free_idx]    = iq.alloc_src2_ready || !iq.alloc_entry.uses_rt ||
                            tag_hit(iq.wb_valid, iq.wb_tag, iq.alloc_entry.src2);
    end
    for (int i = 0; i < INT_QUEUE_SIZE; i++) begin
      occ_d = occ_d + {{INT_QUEUE_SIZE_INDEX{1'b0}}, !avail_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avail_q   <= '1;
      rdy1_q    <= '0;
      rdy2_q    <= '0;
      entries_q <= '0;
      occ_q     <= '0;
    end else begin
      avail_q   <= avail_d;
      rdy1_q    <= rdy1_d;
      rdy2_q    <= rdy2_d;
      entries_q <= entries_d;
      occ_q     <= occ_d;
    end
  end

  assign iq.alloc_ready         = free_found;
  assign iq.entry_available_bit = avail_q;
  assign iq.ready_bit_src1      = rdy1_q;
  assign iq.ready_bit_src2      = rdy2_q;
  assign iq.entries             = entries_q;
  assign iq.occupancy           = occ_q;

  a_dispatch_valid_entry: assert property (@(posedge clk) disable iff (rst)
    iq.dispatch_valid |-> !avail_q[iq.dispatch_index]);

endmodule
